// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - stall bus encodings, sequencer states and hazard helper
package stall_ctrl_pkg;

    localparam int STALL_BUS = 6;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Each pattern stops its own stage and everything upstream of it.
    localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_BUS-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_DIV_BUSY = 2'd1,
        CTRL_DIV_DONE = 2'd2
    } ctrl_state_e;

    function automatic logic reg_hazard(input logic uses, input logic [4:0] src,
                                        input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall sequencer with divide FSM and stall-cycle counter
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 ex_is_load,
    input  logic                 ex_rf_we,
    input  logic [4:0]           ex_rf_waddr,
    input  logic                 div_start,
    input  logic                 mem_stallreq,
    input  logic                 perf_clr,
    output logic [STALL_BUS-1:0] stall,
    output logic                 div_step,
    output logic                 div_ready,
    output logic [31:0]          stall_cycles
);

    ctrl_state_e      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      perf_q;
    logic             ex_req;
    logic             ld_use;
    logic             step_raw, ready_raw;
    logic [STALL_BUS-1:0] stall_raw;

    assign ld_use = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                    (reg_hazard(id_uses_rs, id_rs, ex_rf_waddr) ||
                     reg_hazard(id_uses_rt, id_rt, ex_rf_waddr));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ex_req     = 1'b0;
        step_raw   = 1'b0;
        ready_raw  = 1'b0;
        case (state)
            CTRL_RUN: begin
                // Accepted even under a MEM stall; the divider runs while MEM waits.
                if (div_start) begin
                    ex_req     = 1'b1;
                    cnt_next   = CNT_W'(DIV_CYCLES - 1);
                    state_next = CTRL_DIV_BUSY;
                end
            end
            CTRL_DIV_BUSY: begin
                if (cnt != '0) begin
                    ex_req   = 1'b1;
                    step_raw = 1'b1;
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    ready_raw  = 1'b1;
                    state_next = mem_stallreq ? CTRL_DIV_DONE : CTRL_RUN;
                end
            end
            CTRL_DIV_DONE: begin
                ready_raw = 1'b1;
                if (!mem_stallreq) begin
                    state_next = CTRL_RUN;
                end
            end
            default: begin
                state_next = CTRL_RUN;
            end
        endcase
    end

    always_comb begin
        stall_raw = STALL_NONE;
        if (mem_stallreq) begin
            stall_raw = STALL_MEM;
        end else if (ex_req) begin
            stall_raw = STALL_EX;
        end else if (ld_use) begin
            stall_raw = STALL_ID;
        end
    end

    // Outputs are held quiet while reset is asserted, regardless of state.
    assign stall        = rst ? STALL_NONE : stall_raw;
    assign div_step     = !rst && step_raw;
    assign div_ready    = !rst && ready_raw;
    assign stall_cycles = perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CTRL_RUN;
            cnt    <= '0;
            perf_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (perf_clr) begin
                perf_q <= '0;
            end else if ((stall[0] == STOP) && (perf_q != 32'hFFFF_FFFF)) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

endmodule
